// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer for the pipeline front end.
//
// Owns the fetch PC, issues one request at a time to the instruction memory,
// hands fetched words to IF/ID through a one-entry skid buffer and applies
// EX-stage redirects. A redirect that lands while a request is waiting on
// memory cannot withdraw that request, so the request is marked killed.
// Its data is dropped when it returns, and fetch then resumes at the saved
// target.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   mem_req/mem_addr         request to instruction memory (addr word aligned)
//   mem_ready/mem_rdata      completion and returned word
//   id_stall                 IF/ID cannot accept this cycle
//   redirect_valid/_pc       single-cycle redirect from EX
//   if_valid/if_pc/if_inst   instruction handed to IF/ID
//
// Optional feature (macro FETCH_PERF_CNT_EN): adds perf_fetch_cnt and
// perf_stall_cnt outputs.

module fetch_ctrl #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  id_stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  if_valid,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [DATA_WIDTH-1:0] if_inst
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic                  skid_valid;
    logic [ADDR_WIDTH-1:0] skid_pc;
    logic [DATA_WIDTH-1:0] skid_inst;
    logic                  kill;
    logic [ADDR_WIDTH-1:0] kill_pc;

    logic                  xfer;
    logic                  pend;
    logic                  accept;
    logic                  slot_free;
    logic                  unskid;
    logic [ADDR_WIDTH-1:0] redir_pc;

    // A request is issued in every FETCH cycle; leaving FETCH only happens on
    // a transfer, so an issued request is never withdrawn.
    assign mem_req   = (state == FETCH);
    assign xfer      = mem_req && mem_ready;
    assign pend      = mem_req && !mem_ready;
    assign accept    = xfer && !kill;
    assign slot_free = !if_valid || !id_stall;
    assign unskid    = (state == HOLD) && skid_valid && !id_stall;
    assign redir_pc  = redirect_pc & ~ADDR_WIDTH'(3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = FETCH;
            // Output slot still occupied: the word parks in skid and fetch pauses.
            FETCH:   if (mem_ready && !kill && !slot_free) state_nx = HOLD;
            HOLD:    if (!id_stall) state_nx = FETCH;
            default: state_nx = IDLE;
        endcase
        if (redirect_valid) state_nx = FETCH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr   <= RESET_PC;
            if_valid   <= 1'b0;
            if_pc      <= '0;
            if_inst    <= '0;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_inst  <= '0;
            kill       <= 1'b0;
            kill_pc    <= '0;
        end else if (redirect_valid) begin
            if_valid   <= 1'b0;
            skid_valid <= 1'b0;
            if (pend) begin
                // Request already on the bus: let it finish, drop its data.
                kill    <= 1'b1;
                kill_pc <= redir_pc;
            end else begin
                kill     <= 1'b0;
                mem_addr <= redir_pc;
            end
        end else begin
            if (xfer) begin
                if (kill) begin
                    kill     <= 1'b0;
                    mem_addr <= kill_pc;
                end else begin
                    mem_addr <= mem_addr + ADDR_WIDTH'(4);
                end
            end

            if (accept && slot_free) begin
                if_valid <= 1'b1;
                if_pc    <= mem_addr;
                if_inst  <= mem_rdata;
            end else if (unskid) begin
                if_pc    <= skid_pc;
                if_inst  <= skid_inst;
            end else if (if_valid && !id_stall) begin
                if_valid <= 1'b0;
            end

            if (accept && !slot_free) begin
                skid_valid <= 1'b1;
                skid_pc    <= mem_addr;
                skid_inst  <= mem_rdata;
            end else if (unskid) begin
                skid_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (accept)               perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (if_valid && id_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal expectations, plus a
// transaction-level model (expected address stream and in-order delivery
// queue) checked against the DUT on every cycle. A second instance with
// RESET_PC near the top of the address space exercises PC wrap.

module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_ready, id_stall, redirect_valid, if_valid;
    logic [31:0] mem_addr, mem_rdata, redirect_pc, if_pc, if_inst;

    logic        mem_req2, if_valid2;
    logic        mem_ready2 = 1'b1, id_stall2 = 1'b0, redirect_valid2 = 1'b0;
    logic [31:0] mem_addr2, mem_rdata2, if_pc2, if_inst2;
    logic [31:0] redirect_pc2 = 32'h0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_fetch_cnt2, perf_stall_cnt2;
`endif

    int checks = 0;
    int errors = 0;
    int ws = 0;
    int wcnt = 0;

    always #5 clk = ~clk;

    // Memory: word content is a function of address; ready after ws wait cycles.
    assign mem_rdata  = mem_addr ^ 32'h5A5A_0000;
    assign mem_rdata2 = mem_addr2 ^ 32'h5A5A_0000;
    assign mem_ready  = (wcnt >= ws);

    always @(posedge clk or posedge rst) begin
        if (rst || !mem_req || mem_ready) wcnt <= 0;
        else                              wcnt <= wcnt + 1;
    end

    fetch_ctrl dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .id_stall(id_stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .mem_req(mem_req2), .mem_addr(mem_addr2),
        .mem_ready(mem_ready2), .mem_rdata(mem_rdata2), .id_stall(id_stall2),
        .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .if_valid(if_valid2), .if_pc(if_pc2), .if_inst(if_inst2)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt2), .perf_stall_cnt(perf_stall_cnt2)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    logic [31:0] q_pc[$];
    logic [31:0] q_inst[$];
    logic [31:0] nxt, stale_addr, prev_addr;
    bit          stale, prev_pend;

    always @(negedge clk) begin
        if (rst) begin
            q_pc.delete();
            q_inst.delete();
            nxt       = 32'h0;
            stale     = 1'b0;
            prev_pend = 1'b0;
            prev_addr = 32'h0;
        end else begin
            // An outstanding request must be held stable.
            if (prev_pend) begin
                chk("m_req_held", {31'b0, mem_req}, 32'd1);
                chk("m_addr_held", mem_addr, prev_addr);
            end
            // Presented instruction must be the oldest undelivered fetch.
            if (if_valid) begin
                if (q_pc.size() == 0) begin
                    chk("m_out_unexpected", {31'b0, if_valid}, 32'd0);
                end else begin
                    chk("m_if_pc", if_pc, q_pc[0]);
                    chk("m_if_inst", if_inst, q_inst[0]);
                    if (!id_stall) begin
                        void'(q_pc.pop_front());
                        void'(q_inst.pop_front());
                    end
                end
            end
            if (mem_req) chk("m_mem_addr", mem_addr, stale ? stale_addr : nxt);
            if (mem_req && mem_ready) begin
                if (stale) stale = 1'b0;
                else if (!redirect_valid) begin
                    q_pc.push_back(mem_addr);
                    q_inst.push_back(mem_rdata);
                    nxt = nxt + 32'd4;
                end
            end
            if (redirect_valid) begin
                q_pc.delete();
                q_inst.delete();
                nxt = redirect_pc & ~32'h3;
                if (mem_req && !mem_ready && !stale) begin
                    stale      = 1'b1;
                    stale_addr = mem_addr;
                end
            end
            prev_pend = mem_req && !mem_ready;
            prev_addr = mem_addr;
        end
    end

    // ------------------------------ stimulus -------------------------------
    logic [31:0] spat;

    initial begin
        rst = 1'b1; id_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; ws = 0;
        spat = 32'b1011_0011_1000_0110_0010_1110_0100_1101;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state, IDLE cycle.
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_inst", if_inst, 32'h0);
        tick();
        chk("req_rise", {31'b0, mem_req}, 32'd1);
        chk("first_addr", mem_addr, 32'h0);
        chk("wrap_first_addr", mem_addr2, 32'hFFFF_FFFC);
        tick();
        chk("pc0_valid", {31'b0, if_valid}, 32'd1);
        chk("pc0", if_pc, 32'h0);
        chk("wrap_pc_top", if_pc2, 32'hFFFF_FFFC);
        tick();
        chk("pc4", if_pc, 32'h4);
        chk("req_steady", {31'b0, mem_req}, 32'd1);
        chk("wrap_pc_zero", if_pc2, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("wrap_perf_fetch", perf_fetch_cnt2, 32'd2);
`endif
        tick();
        chk("pc8", if_pc, 32'h8);
        chk("inst8", if_inst, 32'h5A5A_0008);
        tick();
        chk("pcC", if_pc, 32'hC);

        // Stall 3 cycles while fetching: word 0x10 parks in skid.
        id_stall = 1'b1;
        tick();
        chk("hold_req_low", {31'b0, mem_req}, 32'd0);
        chk("hold_pc", if_pc, 32'hC);
        tick();
        chk("hold_req_low2", {31'b0, mem_req}, 32'd0);
        tick();
        id_stall = 1'b0;
        tick();
        chk("unskid_pc", if_pc, 32'h10);
        chk("req_back", {31'b0, mem_req}, 32'd1);
        chk("req_back_addr", mem_addr, 32'h14);
        tick();
        chk("after_skid_pc", if_pc, 32'h14);

        // Redirect to 0x103 with no request pending (in HOLD).
        id_stall = 1'b1;
        tick();
        chk("hold2_req_low", {31'b0, mem_req}, 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        tick();
        redirect_valid = 1'b0; id_stall = 1'b0;
        chk("redir_flush", {31'b0, if_valid}, 32'd0);
        chk("redir_addr", mem_addr, 32'h100);
        chk("redir_req", {31'b0, mem_req}, 32'd1);
        tick();
        chk("redir_pc", if_pc, 32'h100);

        // 3 wait states, redirect to 0x200 during the 2nd wait cycle.
        ws = 3;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        chk("kill_flush", {31'b0, if_valid}, 32'd0);
        chk("kill_addr_held", mem_addr, 32'h104);
        tick();
        chk("kill_xfer_addr", mem_addr, 32'h104);
        tick();
        chk("kill_dropped", {31'b0, if_valid}, 32'd0);
        chk("kill_target", mem_addr, 32'h200);
        ws = 0;
        tick();
        chk("kill_pc", if_pc, 32'h200);

        // Redirect coincident with a transfer (of 0x204).
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect_valid = 1'b0;
        chk("coinc_drop", {31'b0, if_valid}, 32'd0);
        chk("coinc_addr", mem_addr, 32'h300);
        tick();
        chk("coinc_pc", if_pc, 32'h300);
        tick();
        chk("coinc_pc2", if_pc, 32'h304);

        // Two redirects while a request waits: the second target wins.
        ws = 2;
        redirect_valid = 1'b1; redirect_pc = 32'h400;
        tick();
        redirect_pc = 32'h501;
        tick();
        redirect_valid = 1'b0;
        chk("dbl_addr_held", mem_addr, 32'h308);
        tick();
        chk("dbl_target", mem_addr, 32'h500);
        ws = 0;
        tick();
        chk("dbl_pc", if_pc, 32'h500);

        // Mixed stall / wait-state pattern, checked by the model.
        for (int i = 0; i < 32; i++) begin
            id_stall = spat[i];
            ws = (i >= 8 && i < 20) ? 1 : 0;
            tick();
        end
        id_stall = 1'b0; ws = 0;
        repeat (4) tick();

        // Reset in the middle of a waiting request.
        ws = 3;
        tick();
        chk("pre_rst_req", {31'b0, mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_req", {31'b0, mem_req}, 32'd0);
        chk("midrst_valid", {31'b0, if_valid}, 32'd0);
        chk("midrst_addr", mem_addr, 32'h0);
        ws = 0;
        tick();
        tick();
        rst = 1'b0;
        chk("rel_req_low", {31'b0, mem_req}, 32'd0);
        tick();
        chk("rel_req_rise", {31'b0, mem_req}, 32'd1);
        tick();
        chk("rel_pc0", if_pc, 32'h0);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
